block_packer: RTL



---
 rtl/block_packer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/block_packer.sv
// rtl/block_packer.sv - packs receive-RAM nibbles into 64-bit cipher blocks and unpacks results into transmit RAM
//
// Purpose:
//   Walks the 1024-nibble receive RAM as 64 blocks of 16 nibbles. Each block is
//   packed MSB-nibble-first, handed to the cipher over a valid/ready handshake,
//   and the 64-bit result is unpacked into the transmit RAM at the same addresses.
//   odone pulses once all 64 blocks have been stored.
//
// Ports:
//   iclk          - clock, all logic on rising edge
//   irst          - asynchronous active-high reset
//   istart        - one-cycle pulse, process one full RAM block (ignored when busy)
//   oraddr        - receive-RAM read address {blk, k}
//   irdata        - receive-RAM read data, valid one cycle after oraddr
//   owaddr        - transmit-RAM write address {blk, k}
//   owdata        - transmit-RAM write data
//   owrite_en     - transmit-RAM write enable
//   oblock        - packed block to cipher
//   oblock_valid  - oblock valid
//   iblock_ready  - cipher accepts oblock
//   iresult       - cipher output block
//   iresult_valid - iresult valid (single-cycle pulse)
//   obusy         - high whenever the FSM is not idle
//   odone         - one-cycle pulse when all 64 blocks are stored

module block_packer (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic [9:0]  oraddr,
  input  logic [3:0]  irdata,
  output logic [9:0]  owaddr,
  output logic [3:0]  owdata,
  output logic        owrite_en,
  output logic [63:0] oblock,
  output logic        oblock_valid,
  input  logic        iblock_ready,
  input  logic [63:0] iresult,
  input  logic        iresult_valid,
  output logic        obusy,
  output logic        odone
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_RES = 3'd3,
    S_STORE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  blk_q, blk_d;
  logic [4:0]  k_q, k_d;
  logic [63:0] pack_q, pack_d;
  logic [63:0] unpack_q, unpack_d;
  logic        odone_q, odone_d;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q  <= S_IDLE;
      blk_q    <= 6'd0;
      k_q      <= 5'd0;
      pack_q   <= 64'd0;
      unpack_q <= 64'd0;
      odone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      k_q      <= k_d;
      pack_q   <= pack_d;
      unpack_q <= unpack_d;
      odone_q  <= odone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    k_d      = k_q;
    pack_d   = pack_q;
    unpack_d = unpack_q;
    odone_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (istart) begin
          state_d = S_LOAD;
          blk_d   = 6'd0;
          k_d     = 5'd0;
        end
      end

      // k runs 0..16: addresses leave on k = 0..15, and the RAM's one-cycle
      // read latency means the nibble for address k-1 arrives while k is shown.
      S_LOAD: begin
        if (k_q != 5'd0) begin
          pack_d = {pack_q[59:0], irdata};
        end
        if (k_q == 5'd16) begin
          state_d = S_SEND;
        end else begin
          k_d = k_q + 5'd1;
        end
      end

      S_SEND: begin
        if (iblock_ready) begin
          state_d = S_WAIT_RES;
        end
      end

      S_WAIT_RES: begin
        if (iresult_valid) begin
          unpack_d = iresult;
          k_d      = 5'd0;
          state_d  = S_STORE;
        end
      end

      // Shifting out of the top keeps owdata a plain register slice; the
      // register drains to zero so owdata idles at 0 outside STORE.
      S_STORE: begin
        unpack_d = {unpack_q[59:0], 4'h0};
        if (k_q == 5'd15) begin
          k_d = 5'd0;
          if (blk_q == 6'd63) begin
            state_d = S_DONE;
            odone_d = 1'b1;
          end else begin
            blk_d   = blk_q + 6'd1;
            state_d = S_LOAD;
          end
        end else begin
          k_d = k_q + 5'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        blk_d   = 6'd0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign oraddr       = {blk_q, k_q[3:0]};
  assign owaddr       = {blk_q, k_q[3:0]};
  assign owdata       = unpack_q[63:60];
  assign owrite_en    = (state_q == S_STORE);
  assign oblock       = pack_q;
  assign oblock_valid = (state_q == S_SEND);
  assign obusy        = (state_q != S_IDLE);
  assign odone        = odone_q;

endmodule
